// File: rtl/msu_out_collector_if.sv
// -----------------------------------------------------------------------------
// msu_out_collector_if
//
// Bundles the two handshakes of the MSU output collector:
//   * the incoming AXI-Stream word channel (s_axis_*) from the MSU, and
//   * the outgoing result channel (res_*) towards the host-side logic.
//
// Modports:
//   master : the collector itself. It drives s_axis_tready and all res_*
//            outputs, and samples tvalid/tdata/tkeep and res_ready.
//   slave  : the surrounding logic. It drives the stream words and res_ready,
//            and observes tready and the result.
//
// Parameters must match the ones given to msu_out_collector.
// -----------------------------------------------------------------------------
interface msu_out_collector_if #(
    parameter int AXI_LEN     = 32,
    parameter int T_LEN       = 64,
    parameter int SQ_OUT_BITS = 1024
);
    // Stream side
    logic                   s_axis_tvalid;
    logic                   s_axis_tready;
    logic [AXI_LEN-1:0]     s_axis_tdata;
    logic [AXI_LEN/8-1:0]   s_axis_tkeep;

    // Result side
    logic                   res_valid;
    logic                   res_ready;
    logic [T_LEN-1:0]       res_t;
    logic [SQ_OUT_BITS-1:0] res_sq;
    logic                   res_err;
    logic                   res_timeout;

    modport master (
        input  s_axis_tvalid,
        input  s_axis_tdata,
        input  s_axis_tkeep,
        output s_axis_tready,
        output res_valid,
        input  res_ready,
        output res_t,
        output res_sq,
        output res_err,
        output res_timeout
    );

    modport slave (
        output s_axis_tvalid,
        output s_axis_tdata,
        output s_axis_tkeep,
        input  s_axis_tready,
        input  res_valid,
        output res_ready,
        input  res_t,
        input  res_sq,
        input  res_err,
        input  res_timeout
    );
endinterface

// File: rtl/msu_out_collector.sv
// -----------------------------------------------------------------------------
// msu_out_collector
//
// Reassembles the MSU's outgoing word stream (t_current, then sq_out, low word
// first, no tlast) into one wide result and offers it on a valid/ready port.
// While a result is waiting to be consumed the stream is held off
// (s_axis_tready = 0); a start pulse seen in that time is remembered and the
// next collection begins right after the result is taken.
//
// Ports:
//   clk           sole clock, rising edge
//   reset         asynchronous, active-low
//   start_xfer    one-cycle pulse, one cycle before the MSU's first word
//   bus           msu_out_collector_if.master: s_axis_{tvalid,tready,tdata,
//                 tkeep}, res_{valid,ready,t,sq,err,timeout}
//   busy          collector is not idle
//   result_count  number of results consumed since reset (wraps)
//
// States: IDLE -> COLLECT (accept OUT_COUNT words) -> HOLD (present result).
//
// Optional feature (compile-time macro MSU_COLLECT_TIMEOUT_EN):
//   when defined, a stall counter in COLLECT ends a transfer that sees
//   TIMEOUT_CYCLES consecutive cycles without an accepted word; the result is
//   then flagged with res_err and res_timeout. When undefined COLLECT waits
//   forever, res_timeout is constant 0 and no counter exists.
// -----------------------------------------------------------------------------
module msu_out_collector #(
    parameter int AXI_LEN        = 32,
    parameter int T_LEN          = 64,
    parameter int SQ_OUT_BITS    = 1024,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_xfer,
    msu_out_collector_if.master    bus,
    output logic                   busy,
    output logic [31:0]            result_count
);

    localparam int T_WORDS   = T_LEN / AXI_LEN;
    localparam int SQ_WORDS  = SQ_OUT_BITS / AXI_LEN;
    localparam int OUT_COUNT = T_WORDS + SQ_WORDS;
    localparam int BUF_W     = T_LEN + SQ_OUT_BITS;
    localparam int CNT_W     = $clog2(OUT_COUNT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t             state_reg;
    logic [BUF_W-1:0]   shift_reg;
    logic [CNT_W-1:0]   word_cnt_reg;
    logic               start_pending_reg;
    logic               tready_reg;
    logic               res_valid_reg;
    logic               res_err_reg;
    logic               busy_reg;
    logic [31:0]        result_count_reg;

    logic               accept;
    logic               keep_ok;
    logic               last_word;

`ifdef MSU_COLLECT_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0] stall_cnt_reg;
    logic               res_timeout_reg;
`endif

    // tready_reg is high exactly while in COLLECT, so this is the stream
    // handshake without a combinational path back to tready.
    assign accept    = tready_reg && bus.s_axis_tvalid;
    assign keep_ok   = &bus.s_axis_tkeep;
    assign last_word = (word_cnt_reg == CNT_W'(OUT_COUNT - 1));

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs and the reassembly shift register.
    // Words enter at the top and move down, so after OUT_COUNT accepts the
    // first word (low half of t_current) sits in the lowest AXI_LEN bits.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= IDLE;
            shift_reg         <= '0;
            word_cnt_reg      <= '0;
            start_pending_reg <= 1'b0;
            tready_reg        <= 1'b0;
            res_valid_reg     <= 1'b0;
            res_err_reg       <= 1'b0;
            busy_reg          <= 1'b0;
            result_count_reg  <= '0;
`ifdef MSU_COLLECT_TIMEOUT_EN
            stall_cnt_reg     <= '0;
            res_timeout_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_xfer) begin
                        state_reg         <= COLLECT;
                        tready_reg        <= 1'b1;
                        busy_reg          <= 1'b1;
                        word_cnt_reg      <= '0;
                        res_err_reg       <= 1'b0;
                        start_pending_reg <= 1'b0;
`ifdef MSU_COLLECT_TIMEOUT_EN
                        stall_cnt_reg     <= '0;
                        res_timeout_reg   <= 1'b0;
`endif
                    end
                end

                COLLECT: begin
                    // A start for the next transfer may overlap this one.
                    if (start_xfer) begin
                        start_pending_reg <= 1'b1;
                    end
                    if (accept) begin
                        shift_reg    <= {bus.s_axis_tdata, shift_reg[BUF_W-1:AXI_LEN]};
                        word_cnt_reg <= word_cnt_reg + CNT_W'(1);
                        // Partial words are still consumed so the stream
                        // stays aligned; the result is only flagged.
                        if (!keep_ok) begin
                            res_err_reg <= 1'b1;
                        end
                        if (last_word) begin
                            state_reg     <= HOLD;
                            tready_reg    <= 1'b0;
                            res_valid_reg <= 1'b1;
                        end
`ifdef MSU_COLLECT_TIMEOUT_EN
                        stall_cnt_reg <= '0;
`endif
                    end
`ifdef MSU_COLLECT_TIMEOUT_EN
                    else if (stall_cnt_reg == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                        // This idle cycle is the TIMEOUT_CYCLES-th in a row.
                        state_reg       <= HOLD;
                        tready_reg      <= 1'b0;
                        res_valid_reg   <= 1'b1;
                        res_err_reg     <= 1'b1;
                        res_timeout_reg <= 1'b1;
                    end else begin
                        stall_cnt_reg <= stall_cnt_reg + STALL_W'(1);
                    end
`endif
                end

                HOLD: begin
                    if (start_xfer) begin
                        start_pending_reg <= 1'b1;
                    end
                    if (bus.res_ready) begin
                        result_count_reg <= result_count_reg + 32'd1;
                        res_valid_reg    <= 1'b0;
                        // A start coinciding with the handshake goes straight
                        // to COLLECT instead of passing through the pending flag.
                        if (start_pending_reg || start_xfer) begin
                            state_reg         <= COLLECT;
                            tready_reg        <= 1'b1;
                            word_cnt_reg      <= '0;
                            res_err_reg       <= 1'b0;
                            start_pending_reg <= 1'b0;
`ifdef MSU_COLLECT_TIMEOUT_EN
                            stall_cnt_reg     <= '0;
                            res_timeout_reg   <= 1'b0;
`endif
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    tready_reg    <= 1'b0;
                    res_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. The buffer only moves in COLLECT, so in HOLD these are stable.
    // -------------------------------------------------------------------------
    assign bus.s_axis_tready = tready_reg;
    assign bus.res_valid     = res_valid_reg;
    assign bus.res_err       = res_err_reg;
    assign bus.res_t         = shift_reg[T_LEN-1:0];
    assign busy              = busy_reg;
    assign result_count      = result_count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SQ_WORDS; gi++) begin : g_sq_word
            assign bus.res_sq[gi*AXI_LEN +: AXI_LEN] = shift_reg[T_LEN + gi*AXI_LEN +: AXI_LEN];
        end
    endgenerate

`ifdef MSU_COLLECT_TIMEOUT_EN
    assign bus.res_timeout = res_timeout_reg;
`else
    assign bus.res_timeout = 1'b0;
`endif

    // Marker scope that only elaborates for an unusable parameter set
    // (field widths not whole words, or a zero stall limit).
    generate
        if ((T_LEN % AXI_LEN) != 0 || (SQ_OUT_BITS % AXI_LEN) != 0 ||
            TIMEOUT_CYCLES < 1) begin : g_invalid_config
        end
    endgenerate

endmodule

// File: tb/tb_msu_out_collector.sv
// -----------------------------------------------------------------------------
// tb_msu_out_collector
//
// Directed bench for msu_out_collector at default widths, TIMEOUT_CYCLES=16.
// A table of transfer descriptors (t value, sq word pattern, bad-keep word,
// gap pattern, consumer delay, expected error flag) is run in a loop; reset
// mid-collect, backpressure with a pending start, and the stall timeout are
// separate hand-written sequences. Expected results are built from the
// descriptor fields.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_msu_out_collector;

    localparam int AXI_LEN     = 32;
    localparam int T_LEN       = 64;
    localparam int SQ_OUT_BITS = 1024;
    localparam int SQ_WORDS    = SQ_OUT_BITS / AXI_LEN;
    localparam int OUT_COUNT   = T_LEN / AXI_LEN + SQ_WORDS;
    localparam int N_VEC       = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_xfer = 1'b0;
    logic        busy;
    logic [31:0] result_count;

    msu_out_collector_if #(
        .AXI_LEN(AXI_LEN), .T_LEN(T_LEN), .SQ_OUT_BITS(SQ_OUT_BITS)
    ) bus ();

    msu_out_collector #(
        .AXI_LEN(AXI_LEN), .T_LEN(T_LEN), .SQ_OUT_BITS(SQ_OUT_BITS),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_xfer(start_xfer),
        .bus(bus),
        .busy(busy),
        .result_count(result_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] t_val;
        logic [31:0] sq_base;     // sq word k carries sq_base + k
        int          bad_keep;    // word index sent with tkeep=0111, -1 none
        int          gap_every;   // one idle cycle after this many words, 0 none
        int          ready_delay; // HOLD cycles before res_ready
        logic        exp_err;
    } vec_t;

    vec_t        vecs [N_VEC];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_count = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1023:0] act,
                         input logic [1023:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int idx, input int k);
        if (k == 0)      return vecs[idx].t_val[31:0];
        else if (k == 1) return vecs[idx].t_val[63:32];
        else             return vecs[idx].sq_base + 32'(k - 2);
    endfunction

    function automatic logic [SQ_OUT_BITS-1:0] exp_sq(input int idx);
        logic [SQ_OUT_BITS-1:0] v;
        for (int k = 0; k < SQ_WORDS; k++) v[k*32 +: 32] = vecs[idx].sq_base + 32'(k);
        return v;
    endfunction

    // Pulse start and confirm tready rises on the next cycle.
    task automatic start_pulse();
        start_xfer = 1'b1;
        step();
        start_xfer = 1'b0;
        check("tready_after_start", 1024'(bus.s_axis_tready), 1024'(1));
    endtask

    // Feed n_words of vector idx (bounded), counting only real handshakes.
    task automatic send_words(input int idx, input int n_words);
        int   acc = 0;
        int   cyc = 0;
        int   since_gap = 0;
        logic was_acc;
        while (acc < n_words && cyc < 400) begin
            if (vecs[idx].gap_every > 0 && since_gap == vecs[idx].gap_every) begin
                bus.s_axis_tvalid = 1'b0;
                since_gap = 0;
            end else begin
                bus.s_axis_tvalid = 1'b1;
                bus.s_axis_tdata  = word_of(idx, acc);
                bus.s_axis_tkeep  = (acc == vecs[idx].bad_keep) ? 4'b0111 : 4'b1111;
            end
            was_acc = bus.s_axis_tvalid && bus.s_axis_tready;
            step();
            if (was_acc) begin
                acc++;
                since_gap++;
            end
            cyc++;
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tkeep  = 4'b1111;
        check("words_accepted", 1024'(acc), 1024'(n_words));
        if (n_words == OUT_COUNT) begin
            check("res_valid_after_last", 1024'(bus.res_valid), 1024'(1));
            check("tready_in_hold", 1024'(bus.s_axis_tready), 1024'(0));
        end else begin
            check("res_valid_mid", 1024'(bus.res_valid), 1024'(0));
            check("tready_mid", 1024'(bus.s_axis_tready), 1024'(1));
        end
    endtask

    task automatic check_fields(input int idx, input logic exp_err);
        check("res_t", 1024'(bus.res_t), 1024'(vecs[idx].t_val));
        check("res_sq", 1024'(bus.res_sq), 1024'(exp_sq(idx)));
        check("res_err", 1024'(bus.res_err), 1024'(exp_err));
        check("res_timeout", 1024'(bus.res_timeout), 1024'(0));
    endtask

    // Wait, check, consume; the collector should return to IDLE.
    task automatic consume(input int idx);
        for (int c = 0; c < vecs[idx].ready_delay; c++) step();
        check("res_valid_held", 1024'(bus.res_valid), 1024'(1));
        check_fields(idx, vecs[idx].exp_err);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        exp_count++;
        check("res_valid_after_hs", 1024'(bus.res_valid), 1024'(0));
        check("busy_after_hs", 1024'(busy), 1024'(0));
        check("result_count", 1024'(result_count), 1024'(exp_count));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tready"}, 1024'(bus.s_axis_tready), 1024'(0));
        check({tag, "_res_valid"}, 1024'(bus.res_valid), 1024'(0));
        check({tag, "_res_t"}, 1024'(bus.res_t), 1024'(0));
        check({tag, "_res_sq"}, 1024'(bus.res_sq), 1024'(0));
        check({tag, "_res_err"}, 1024'(bus.res_err), 1024'(0));
        check({tag, "_res_timeout"}, 1024'(bus.res_timeout), 1024'(0));
        check({tag, "_busy"}, 1024'(busy), 1024'(0));
        check({tag, "_count"}, 1024'(result_count), 1024'(0));
    endtask

    initial begin
        int idle_cycles;

        //            t_val                    sq_base        bad gap dly err
        vecs[0] = '{64'd5,                     32'd2,         -1, 0,  0, 1'b0};
        vecs[1] = '{64'hDEADBEEF_CAFEF00D,     32'h1000_0000,  7, 0,  3, 1'b1};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF,   32'hFFFF_FFF0, -1, 3,  1, 1'b0};
        vecs[3] = '{64'd0,                     32'h8000_0000, 33, 0,  0, 1'b1};
        vecs[4] = '{64'h8000_0000_0000_0000,   32'h5555_5555,  0, 5,  2, 1'b1};

        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tkeep  = 4'b1111;
        bus.res_ready     = 1'b0;

        // Power-on reset values.
        step();
        step();
        check_reset_values("por");
        reset = 1'b1;
        step();

        // Reset in the middle of a collection.
        start_pulse();
        send_words(0, 10);
        reset = 1'b0;
        #1;
        check_reset_values("midrst");
        step();
        step();
        reset = 1'b1;
        step();

        // Table of full transfers (includes the basic case and bad keep).
        for (int v = 0; v < N_VEC; v++) begin
            start_pulse();
            send_words(v, OUT_COUNT);
            consume(v);
            $display("vector %0d: t=%0h sq_base=%0h bad_keep=%0d count=%0d",
                     v, vecs[v].t_val, vecs[v].sq_base, vecs[v].bad_keep, result_count);
        end

        // Backpressure: result held 50 cycles, start arrives during HOLD.
        start_pulse();
        send_words(0, OUT_COUNT);
        begin
            logic tready_seen = 1'b0;
            logic valid_drop  = 1'b0;
            for (int c = 0; c < 50; c++) begin
                start_xfer = (c == 10);
                step();
                start_xfer = 1'b0;
                if (bus.s_axis_tready) tready_seen = 1'b1;
                if (!bus.res_valid)    valid_drop  = 1'b1;
            end
            check("bp_tready_low", 1024'(tready_seen), 1024'(0));
            check("bp_valid_held", 1024'(valid_drop), 1024'(0));
        end
        check_fields(0, 1'b0);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        exp_count++;
        check("bp_tready_pending", 1024'(bus.s_axis_tready), 1024'(1));
        check("bp_res_valid_low", 1024'(bus.res_valid), 1024'(0));
        check("bp_busy", 1024'(busy), 1024'(1));
        send_words(1, OUT_COUNT);
        check_fields(1, 1'b1);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        exp_count++;
        check("bp_result_count", 1024'(result_count), 1024'(exp_count));
        $display("backpressure: count=%0d", result_count);

        // Stall after 20 words.
        start_pulse();
        send_words(2 - 2, 20);
`ifdef MSU_COLLECT_TIMEOUT_EN
        idle_cycles = 0;
        while (!bus.res_valid && idle_cycles < 100) begin
            step();
            idle_cycles++;
        end
        check("to_idle_cycles", 1024'(idle_cycles), 1024'(16));
        check("to_res_err", 1024'(bus.res_err), 1024'(1));
        check("to_res_timeout", 1024'(bus.res_timeout), 1024'(1));
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        exp_count++;
        check("to_result_count", 1024'(result_count), 1024'(exp_count));
        check("to_busy", 1024'(busy), 1024'(0));
`else
        idle_cycles = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            idle_cycles++;
        end
        check("stall_res_valid", 1024'(bus.res_valid), 1024'(0));
        check("stall_busy", 1024'(busy), 1024'(1));
        check("stall_tready", 1024'(bus.s_axis_tready), 1024'(1));
        check("stall_res_timeout", 1024'(bus.res_timeout), 1024'(0));
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("stall_reset_busy", 1024'(busy), 1024'(0));
`endif
        $display("stall: %0d idle cycles observed, res_valid=%0d", idle_cycles, bus.res_valid);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
